lib_voq_credit_scheduler: RTL and testbench
===========================================

# lib_voq_credit_scheduler

Credit-based round-robin scheduler that sits directly downstream of a router input port's virtual output queue (VOQ) bank. Each cycle it examines the per-output non-empty flags from the VOQ and the per-output credit counters tracking free space in the downstream buffers. It issues at most one onehot dequeue enable back to the VOQ and a registered onehot switch select to the crossbar. Credits returned by downstream buffers replenish the counters.

## Interface
- `M`, 4: number of outputs; one VOQ and one credit counter per output; M ≥ 2.
- `CREDITS`, 4: downstream buffer depth per output; reset value and maximum of each credit counter; CREDITS ≥ 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset: synchronous, active-high.
- `ce`  in  1  clock enable; when low, all state holds and `o_en` is 0.
- `i_data_val`  in  [0:M-1]  VOQ non-empty flags; bit j set means VOQ j holds a packet. Index 0 is leftmost.
- `i_credit`  in  [0:M-1]  credit return; a one-cycle pulse on bit j returns one credit for output j.
- `o_en`  out  [0:M-1]  onehot-or-zero dequeue enable to VOQ j; combinational from current state and inputs.
- `o_sel`  out  [0:M-1]  registered copy of the previous cycle's `o_en`; drives the crossbar select aligned with the VOQ output data.
- `o_avail`  out  [0:M-1]  bit j = (credit counter j > 0); registered state, decoded combinationally.
- `o_credit_err`  out  1  sticky flag; set by a credit return to a counter already at CREDITS.

## Operation
- State:
  - `cnt[j]`, width $clog2(CREDITS+1), for each output j.
  - Round-robin pointer `ptr`, width $clog2(M), range 0..M-1.
  - `o_sel` register.
  - `o_credit_err` register.
- Eligibility: output j is eligible when `i_data_val[j]` and `cnt[j] != 0` are both true.
- Grant:
  - Search j = ptr, ptr+1, …, wrapping modulo M.
  - The first eligible j wins, and `o_en` is set to the onehot of j.
  - If no output is eligible, or `ce` = 0, or `reset` = 1, `o_en` = 0.
- Pointer update, on a grant to j only: `ptr` ← (j+1) mod M. Wrap-around: a grant at M-1 sets `ptr` to 0. With no grant, `ptr` holds.
- Counter update, per j, when `ce` = 1:
  - Grant only: `cnt` − 1.
  - Credit only: `cnt` + 1.
  - Grant and credit in the same cycle: unchanged.
- Saturation at CREDITS: a credit-only return with `cnt[j]` = CREDITS leaves the counter at CREDITS and sets `o_credit_err`.
- Underflow is impossible because a grant requires `cnt` > 0.
- `o_sel` ← `o_en` on every `ce` = 1 edge. This includes loading zeros when there is no grant.
- `ce` = 0: all registers hold, `i_credit` is ignored, and `o_en` = 0. Upstream and downstream share `ce`, so credits are only pulsed while `ce` = 1.
- Reset (synchronous, overrides `ce`):
  - `cnt[*]` = CREDITS, `ptr` = 0, `o_sel` = 0, `o_credit_err` = 0.
  - `o_en` is forced to 0 combinationally while `reset` = 1.
  - Reset asserted mid-operation discards in-flight credit state. A re-reset requires downstream buffers to be reset in the same cycle.

## Timing
- Grant latency: 0 cycles; `o_en` is asserted in the same cycle `i_data_val` and credit are present.
- The VOQ pops on the edge that ends the grant cycle. `o_sel` is valid in the following cycle.
- Credit latency: a credit pulse in cycle t is visible as `cnt` + 1 in cycle t+1, so it can enable a grant in t+1.
- Grant throughput: at most 1 per cycle. Back-to-back grants to the same output are allowed when it is the only eligible output.
- Fairness: with all M outputs continuously eligible, grants cycle 0,1,…,M-1,0. No output waits more than M-1 grants.
- The `o_en` combinational path is `i_data_val` → priority search → `o_en`. It must not depend on `o_en` itself, so no loop through the VOQ.

## Test plan
- **Reset values:**
  - Stimulus: M=4, CREDITS=2; reset for 2 cycles, then `i_data_val` = 0.
  - Required: `o_en` = 0, `o_sel` = 0, `o_avail` = 1111, `o_credit_err` = 0.
- **Round-robin order:**
  - Stimulus: `i_data_val` = 1111, with one credit pulse returned per output every cycle.
  - Required: `o_en` sequence 1000, 0100, 0010, 0001, 1000; `o_sel` lags by exactly 1 cycle.
- **Credit exhaustion:**
  - Stimulus: `i_data_val` = 1000 only, no credits returned.
  - Required: grants in 2 consecutive cycles, then `o_en` = 0 and `o_avail` = 0111. A single `i_credit` = 1000 pulse yields exactly one further grant on the next cycle.
- **Simultaneous grant and credit:**
  - Stimulus: `cnt[0]` = 1; `i_data_val` = 1000 and `i_credit` = 1000 in the same cycle.
  - Required: grant issued and `cnt[0]` stays 1. Repeating this for 10 cycles gives 10 grants with `o_avail[0]` = 1 throughout.
- **ce gating and credit overflow:**
  - Stimulus: `ce` = 0 for 3 cycles with `i_data_val` = 1111 and `i_credit` = 1111.
  - Required: `o_en` = 0, all state unchanged, `o_credit_err` = 0.
  - Follow-on stimulus: with `ce` = 1, `cnt` = 2 and `i_credit` = 0100.
  - Required: `o_credit_err` = 1 next cycle and stays set until reset.
- **Skip ineligible and reset mid-stream:**
  - Stimulus: `ptr` = 1, `i_data_val` = 1001, `cnt[3]` = 0.
  - Required: `o_en` = 1000, `ptr` → 1.
  - Follow-on stimulus: assert `reset` during an active grant.
  - Required: `o_en` = 0 in that cycle; next cycle `cnt[*]` = 2 and `ptr` = 0.

Source files
------------

// File: rtl/lib_voq_credit_scheduler_if.sv
// VOQ-side and crossbar-side signal bundle for the credit scheduler.
// The scheduler takes the slave view; the VOQ/credit environment takes the master view.
interface lib_voq_credit_scheduler_if #(
  parameter int M = 4
);
  logic [0:M-1] i_data_val;
  logic [0:M-1] i_credit;
  logic [0:M-1] o_en;
  logic [0:M-1] o_sel;
  logic [0:M-1] o_avail;
  logic         o_credit_err;

  modport master (
    output i_data_val, i_credit,
    input  o_en, o_sel, o_avail, o_credit_err
  );

  modport slave (
    input  i_data_val, i_credit,
    output o_en, o_sel, o_avail, o_credit_err
  );
endinterface

// File: rtl/lib_voq_credit_scheduler.sv
// Credit-based round-robin scheduler for one router input's VOQ bank: combinational
// onehot dequeue grant, registered crossbar select, per-output credit counters.
module lib_voq_credit_scheduler #(
  parameter int M       = 4,
  parameter int CREDITS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ce,
  lib_voq_credit_scheduler_if.slave  bus
);
  localparam int PW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  logic [CW-1:0] cnt [M];
  logic [PW-1:0] ptr;
  logic [0:M-1]  sel_p1;
  logic          credit_err;

  logic [0:M-1]  elig;
  logic [0:M-1]  grant;
  logic [0:M-1]  ovf;
  logic [PW-1:0] gidx;
  logic          gvld;

  // Grant and credit in the same cycle cancel; a credit into a full counter saturates.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                             input logic g, input logic r);
    if (g && !r)                 return c - CW'(1);
    if (r && !g && (c != CMAX))  return c + CW'(1);
    return c;
  endfunction

  function automatic logic cnt_overflow(input logic [CW-1:0] c,
                                        input logic g, input logic r);
    return r && !g && (c == CMAX);
  endfunction

  always_comb begin
    for (int j = 0; j < M; j++) begin
      elig[j] = bus.i_data_val[j] && (cnt[j] != '0);
    end
  end

  // Rotating priority search starting at ptr; depends only on inputs and state.
  always_comb begin
    gvld = 1'b0;
    gidx = '0;
    for (int k = 0; k < M; k++) begin
      if (!gvld && elig[(int'(ptr) + k) % M]) begin
        gvld = 1'b1;
        gidx = PW'((int'(ptr) + k) % M);
      end
    end
    if (reset || !ce) gvld = 1'b0;
  end

  always_comb begin
    grant = '0;
    if (gvld) grant[gidx] = 1'b1;
  end

  always_comb begin
    for (int j = 0; j < M; j++) begin
      ovf[j] = cnt_overflow(cnt[j], grant[j], bus.i_credit[j]);
    end
  end

  // Stage p0 -> p1: counters, pointer and crossbar select update on the grant edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      sel_p1     <= '0;
      credit_err <= 1'b0;
      for (int j = 0; j < M; j++) cnt[j] <= CMAX;
    end else if (ce) begin
      sel_p1 <= grant;
      if (gvld) ptr <= (gidx == PW'(M - 1)) ? '0 : gidx + PW'(1);
      for (int j = 0; j < M; j++) begin
        cnt[j] <= cnt_next(cnt[j], grant[j], bus.i_credit[j]);
      end
      if (|ovf) credit_err <= 1'b1;
    end
  end

  always_comb begin
    for (int j = 0; j < M; j++) begin
      bus.o_avail[j] = (cnt[j] != '0);
    end
  end

  assign bus.o_en         = grant;
  assign bus.o_sel        = sel_p1;
  assign bus.o_credit_err = credit_err;
endmodule

// File: tb/tb_lib_voq_credit_scheduler.sv
// Bench for lib_voq_credit_scheduler (M=4, CREDITS=2): directed vector table for the
// corner sequences, then randomized traffic checked against a queue-level reference model.
module tb_lib_voq_credit_scheduler;
  localparam int M       = 4;
  localparam int CREDITS = 2;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  lib_voq_credit_scheduler_if #(.M(M)) bus ();

  lib_voq_credit_scheduler #(.M(M), .CREDITS(CREDITS)) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ce;
    logic       rst;
    logic [0:3] dv;
    logic [0:3] cr;
    logic [0:3] en;
    logic [0:3] sel;
    logic [0:3] avail;
    logic       err;
    logic       chk;
  } vec_t;

  vec_t tv[$];
  int errors = 0;
  int checks = 0;

  // Reference model state: credits held per output, next output to favour, last grant.
  int         mcnt [M];
  int         mptr;
  logic [0:3] msel;
  logic       merr;

  task automatic add(input logic c, input logic r, input logic [0:3] dv, input logic [0:3] cr,
                     input logic [0:3] en, input logic [0:3] sel, input logic [0:3] av,
                     input logic e, input logic chk);
    vec_t v;
    v.ce = c; v.rst = r; v.dv = dv; v.cr = cr;
    v.en = en; v.sel = sel; v.avail = av; v.err = e; v.chk = chk;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic r, input logic [0:3] dv, input logic [0:3] cr);
    @(negedge clk);
    ce = c; reset = r;
    bus.i_data_val = dv;
    bus.i_credit   = cr;
    #2;
  endtask

  function automatic int model_grant(input logic c, input logic r, input logic [0:3] dv);
    int g = -1;
    if (c && !r) begin
      for (int k = 0; k < M; k++) begin
        int j = (mptr + k) % M;
        if (g < 0 && dv[j] && mcnt[j] > 0) g = j;
      end
    end
    return g;
  endfunction

  function automatic logic [0:3] onehot(input int g);
    logic [0:3] v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [0:3] model_avail();
    logic [0:3] v;
    for (int j = 0; j < M; j++) v[j] = (mcnt[j] > 0);
    return v;
  endfunction

  task automatic model_step(input logic c, input logic r, input logic [0:3] cr, input int g);
    if (r) begin
      for (int j = 0; j < M; j++) mcnt[j] = CREDITS;
      mptr = 0; msel = '0; merr = 1'b0;
    end else if (c) begin
      for (int j = 0; j < M; j++) begin
        if (g == j && !cr[j]) mcnt[j]--;
        else if (g != j && cr[j]) begin
          if (mcnt[j] == CREDITS) merr = 1'b1;
          else mcnt[j]++;
        end
      end
      msel = onehot(g);
      if (g >= 0) mptr = (g + 1) % M;
    end
  endtask

  initial begin
    ce = 1'b0; reset = 1'b1;
    bus.i_data_val = '0;
    bus.i_credit   = '0;

    // reset values
    add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 0);
    add(1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 1);
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 1);
    // round robin, granted credit returned alongside
    add(1, 0, 4'b1111, 4'b1000, 4'b1000, 4'b0000, 4'b1111, 0, 1);
    add(1, 0, 4'b1111, 4'b0100, 4'b0100, 4'b1000, 4'b1111, 0, 1);
    add(1, 0, 4'b1111, 4'b0010, 4'b0010, 4'b0100, 4'b1111, 0, 1);
    add(1, 0, 4'b1111, 4'b0001, 4'b0001, 4'b0010, 4'b1111, 0, 1);
    add(1, 0, 4'b1111, 4'b1000, 4'b1000, 4'b0001, 4'b1111, 0, 1);
    // credit exhaustion on output 0
    add(1, 0, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b1111, 0, 1);
    add(1, 0, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b1111, 0, 1);
    add(1, 0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0111, 0, 1);
    add(1, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0111, 0, 1);
    add(1, 0, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1111, 0, 1);
    add(1, 0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0111, 0, 1);
    // bring cnt[0] to 1, then grant+credit for 10 cycles
    add(1, 0, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0111, 0, 1);
    for (int i = 0; i < 10; i++)
      add(1, 0, 4'b1000, 4'b1000, 4'b1000, (i == 0) ? 4'b0000 : 4'b1000, 4'b1111, 0, 1);
    // ce gating
    for (int i = 0; i < 3; i++)
      add(0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b1000, 4'b1111, 0, 1);
    // overflow on output 2, sticky error
    add(1, 0, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b1111, 0, 1);
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1, 1);
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1, 1);
    // drain output 3 (pointer wraps), park ptr at 1, then skip ineligible
    add(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b1111, 1, 1);
    add(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b1111, 1, 1);
    add(1, 0, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b1110, 1, 1);
    add(1, 0, 4'b1001, 4'b0000, 4'b1000, 4'b1000, 4'b1110, 1, 1);
    add(1, 0, 4'b1111, 4'b1001, 4'b0100, 4'b1000, 4'b0110, 1, 1);
    // reset mid-stream, then show ptr=0 and cnt[0]=2
    add(1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b1111, 1, 1);
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 1);
    add(1, 0, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 4'b1111, 0, 1);
    add(1, 0, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b1111, 0, 1);
    add(1, 0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0111, 0, 1);

    foreach (tv[i]) begin
      drive(tv[i].ce, tv[i].rst, tv[i].dv, tv[i].cr);
      if (tv[i].chk) begin
        check("o_en",         i, bus.o_en,                tv[i].en);
        check("o_sel",        i, bus.o_sel,               tv[i].sel);
        check("o_avail",      i, bus.o_avail,             tv[i].avail);
        check("o_credit_err", i, {3'b000, bus.o_credit_err}, {3'b000, tv[i].err});
      end
    end

    // Randomized traffic against the reference model, starting from a reset.
    drive(1, 1, 4'b0000, 4'b0000);
    model_step(1, 1, 4'b0000, -1);
    for (int n = 0; n < 600; n++) begin
      logic       c, r;
      logic [0:3] dv, cr;
      int         g;
      c  = ($urandom_range(0, 7) != 0);
      r  = ($urandom_range(0, 99) == 0);
      dv = 4'($urandom);
      g  = model_grant(c, r, dv);
      cr = '0;
      for (int j = 0; j < M; j++)
        if (mcnt[j] < CREDITS || g == j) cr[j] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) cr = 4'b1111;
      drive(c, r, dv, cr);
      check("rand o_en",         1000 + n, bus.o_en,    onehot(g));
      check("rand o_sel",        1000 + n, bus.o_sel,   msel);
      check("rand o_avail",      1000 + n, bus.o_avail, model_avail());
      check("rand o_credit_err", 1000 + n, {3'b000, bus.o_credit_err}, {3'b000, merr});
      model_step(c, r, cr, g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
